// File: rtl/adaptive_route_unit_pkg.sv
// Shared definitions for adaptive_route_unit: direction codes, port-relative
// channel mapping, routing-algorithm encodings and FSM states.
package adaptive_route_unit_pkg;

  localparam logic [2:0] DIR_PE    = 3'd0;
  localparam logic [2:0] DIR_X_POS = 3'd1;
  localparam logic [2:0] DIR_Y_POS = 3'd2;
  localparam logic [2:0] DIR_X_NEG = 3'd3;
  localparam logic [2:0] DIR_Y_NEG = 3'd4;
  localparam int         NUM_DIRS  = 5;

  localparam int ALGO_XY         = 0;
  localparam int ALGO_WEST_FIRST = 1;
  localparam int ALGO_NEG_FIRST  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

  // Channel bits list the four directions other than the input port, in
  // ascending direction-code order.
  function automatic logic [1:0] chan_bit(logic [2:0] port, logic [2:0] dir);
    return (dir < port) ? dir[1:0] : 2'(dir - 3'd1);
  endfunction

  function automatic logic [3:0] port_relative(logic [4:0] dirs, logic [2:0] port);
    logic [3:0] rel;
    rel = '0;
    for (int d = 0; d < NUM_DIRS; d++) begin
      if (3'(d) != port) rel[chan_bit(port, 3'(d))] = dirs[3'(d)];
    end
    return rel;
  endfunction

endpackage

// File: rtl/adaptive_route_unit_if.sv
// Head/credit/route bundle between a link controller and its route planner.
interface adaptive_route_unit_if #(
  parameter int ADDR_W   = 4,
  parameter int CREDIT_W = 3
);
  logic                  head_valid_din;
  logic                  head_ready_dout;
  logic                  done_field_din;
  logic [ADDR_W-1:0]     x_field_din;
  logic [ADDR_W-1:0]     y_field_din;
  logic [4*CREDIT_W-1:0] credit_din;
  logic                  tail_din;
  logic [3:0]            valid_channels_dout;
  logic                  route_valid_dout;
  logic [3:0]            route_onehot_dout;
  logic                  route_err_dout;

  modport master (
    output head_valid_din, done_field_din, x_field_din, y_field_din, credit_din, tail_din,
    input  head_ready_dout, valid_channels_dout, route_valid_dout, route_onehot_dout,
           route_err_dout
  );

  modport slave (
    input  head_valid_din, done_field_din, x_field_din, y_field_din, credit_din, tail_din,
    output head_ready_dout, valid_channels_dout, route_valid_dout, route_onehot_dout,
           route_err_dout
  );
endinterface

// File: rtl/adaptive_route_unit_route_candidates.sv
// Turn-model candidate set for one input port, in port-relative channel order.
module route_candidates
  import adaptive_route_unit_pkg::*;
#(
  parameter logic [2:0] PORT_DIR = DIR_X_POS,
  parameter int X_LOCAL = 2,
  parameter int Y_LOCAL = 2,
  parameter int X_WIDTH = 2,
  parameter int Y_WIDTH = 2,
  parameter int ADDR_W  = 4,
  parameter int ALGO    = 1
) (
  input  logic [ADDR_W-1:0] x_field,
  input  logic [ADDR_W-1:0] y_field,
  input  logic              done_field,
  output logic [3:0]        candidates
);
  localparam logic [ADDR_W-1:0] XL = ADDR_W'(X_LOCAL);
  localparam logic [ADDR_W-1:0] YL = ADDR_W'(Y_LOCAL);
  localparam logic [ADDR_W-1:0] XW = ADDR_W'(X_WIDTH);
  localparam logic [ADDR_W-1:0] YW = ADDR_W'(Y_WIDTH);

  logic       x_pos, x_neg, y_pos, y_neg, at_local, in_mesh;
  logic [4:0] dirs;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    dirs     = '0;
    x_pos    = x_field > XL;
    x_neg    = x_field < XL;
    y_pos    = y_field > YL;
    y_neg    = y_field < YL;
    at_local = !(x_pos || x_neg || y_pos || y_neg);
    // Coordinates are 1-based; anything off the mesh has no productive direction.
    in_mesh  = (x_field != '0) && (x_field <= XW) && (y_field != '0) && (y_field <= YW);

    if (ALGO == ALGO_XY) begin
      if (x_pos || x_neg) begin
        dirs[DIR_X_POS] = x_pos;
        dirs[DIR_X_NEG] = x_neg;
      end else begin
        dirs[DIR_Y_POS] = y_pos;
        dirs[DIR_Y_NEG] = y_neg;
      end
    end else if (ALGO == ALGO_WEST_FIRST) begin
      if (x_neg) begin
        dirs[DIR_X_NEG] = 1'b1;
      end else begin
        dirs[DIR_X_POS] = x_pos;
        dirs[DIR_Y_POS] = y_pos;
        dirs[DIR_Y_NEG] = y_neg;
      end
    end else begin
      if (x_neg || y_neg) begin
        dirs[DIR_X_NEG] = x_neg;
        dirs[DIR_Y_NEG] = y_neg;
      end else begin
        dirs[DIR_X_POS] = x_pos;
        dirs[DIR_Y_POS] = y_pos;
      end
    end

    if (at_local) begin
      dirs[DIR_PE] = !done_field;
      if (X_LOCAL == 1)       dirs[DIR_X_NEG] = 1'b1;
      if (X_LOCAL == X_WIDTH) dirs[DIR_X_POS] = 1'b1;
    end

    candidates = in_mesh ? port_relative(dirs, PORT_DIR) : 4'b0000;
  end
endmodule

// File: rtl/adaptive_route_unit.sv
// Registered route planner with credit-gated output selection and packet lock.
// Optional ROUTE_CREDIT_SEL_EN: highest-credit selection with round-robin ties.
module adaptive_route_unit
  import adaptive_route_unit_pkg::*;
#(
  parameter logic [2:0] PORT_DIR = DIR_X_POS,
  parameter int X_LOCAL  = 2,
  parameter int Y_LOCAL  = 2,
  parameter int X_WIDTH  = 2,
  parameter int Y_WIDTH  = 2,
  parameter int ADDR_W   = 4,
  parameter int ALGO     = 1,
  parameter int CREDIT_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  adaptive_route_unit_if.slave    bus
);
  state_e              state;
  logic [ADDR_W-1:0]   x_q, y_q;
  logic                done_q;
  logic                head_ready_q, route_valid_q, route_err_q;
  logic [3:0]          route_onehot_q;
  logic [3:0]          cand, eligible;
  logic [CREDIT_W-1:0] credit [4];
  logic                found;
  logic [1:0]          sel_idx;

  route_candidates #(
    .PORT_DIR(PORT_DIR), .X_LOCAL(X_LOCAL), .Y_LOCAL(Y_LOCAL), .X_WIDTH(X_WIDTH),
    .Y_WIDTH(Y_WIDTH), .ADDR_W(ADDR_W), .ALGO(ALGO)
  ) u_route_candidates (
    .x_field(x_q), .y_field(y_q), .done_field(done_q), .candidates(cand)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      credit[i]   = bus.credit_din[i*CREDIT_W +: CREDIT_W];
      eligible[i] = cand[i] && (credit[i] != '0);
    end
  end

`ifdef ROUTE_CREDIT_SEL_EN
  logic [1:0]          rr_ptr;
  logic [1:0]          idx;
  logic [CREDIT_W-1:0] best_credit;

  // Scanning from rr_ptr with a strict '>' makes the first tied output win.
  always_comb begin
    found       = 1'b0;
    sel_idx     = rr_ptr;
    best_credit = '0;
    idx         = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (eligible[idx] && (!found || credit[idx] > best_credit)) begin
        found       = 1'b1;
        sel_idx     = idx;
        best_credit = credit[idx];
      end
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (cand[i]) sel_idx = 2'(i);
    end
    found = eligible[sel_idx];
  end
`endif

  // NOTE: captured head fields carry no reset; they are only observed outside IDLE.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.head_valid_din) begin
      x_q    <= bus.x_field_din;
      y_q    <= bus.y_field_din;
      done_q <= bus.done_field_din;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      head_ready_q   <= 1'b1;
      route_valid_q  <= 1'b0;
      route_onehot_q <= '0;
      route_err_q    <= 1'b0;
`ifdef ROUTE_CREDIT_SEL_EN
      rr_ptr         <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.head_valid_din) begin
            state        <= ST_SELECT;
            head_ready_q <= 1'b0;
          end
        end
        ST_SELECT: begin
          if (cand == 4'b0000) begin
            route_err_q  <= 1'b1;
            head_ready_q <= 1'b1;
            state        <= ST_IDLE;
          end else if (found) begin
            route_onehot_q <= 4'b0001 << sel_idx;
            route_valid_q  <= 1'b1;
`ifdef ROUTE_CREDIT_SEL_EN
            rr_ptr         <= sel_idx + 2'd1;
`endif
            state          <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.tail_din) begin
            route_valid_q  <= 1'b0;
            route_onehot_q <= '0;
            head_ready_q   <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        default: begin
          state        <= ST_IDLE;
          head_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.head_ready_dout     = head_ready_q;
  assign bus.route_valid_dout    = route_valid_q;
  assign bus.route_onehot_dout   = route_onehot_q;
  assign bus.route_err_dout      = route_err_q;
  assign bus.valid_channels_dout = (state == ST_IDLE) ? 4'b0000 : cand;
endmodule

// File: tb/tb_adaptive_route_unit.sv
// Directed bench: four planner instances checked every cycle against a
// transaction-level route model, plus hand-computed spot checks.
module tb_adaptive_route_unit;
  // Direction codes: PE=0, X_POS=1, Y_POS=2, X_NEG=3, Y_NEG=4.
  localparam int P_PORT [4] = '{3, 0, 0, 0};
  localparam int P_X    [4] = '{2, 1, 2, 2};
  localparam int P_Y    [4] = '{2, 2, 2, 2};
  localparam int P_XW   [4] = '{4, 4, 4, 4};
  localparam int P_YW   [4] = '{4, 4, 4, 4};
  localparam int P_ALGO [4] = '{1, 1, 2, 0};
  localparam int PH_IDLE = 0, PH_SEL = 1, PH_HOLD = 2;

  logic clk = 1'b0;
  logic rst;
  logic started = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  logic [3:0]        hv, dn, tl;
  logic [3:0][3:0]   xf, yf;
  logic [3:0][11:0]  cr;
  logic [3:0]        rdy, rv, err;
  logic [3:0][3:0]   vc, oh;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    adaptive_route_unit_if #(.ADDR_W(4), .CREDIT_W(3)) bus ();
    assign bus.head_valid_din = hv[g];
    assign bus.done_field_din = dn[g];
    assign bus.x_field_din    = xf[g];
    assign bus.y_field_din    = yf[g];
    assign bus.credit_din     = cr[g];
    assign bus.tail_din       = tl[g];
    assign rdy[g] = bus.head_ready_dout;
    assign vc[g]  = bus.valid_channels_dout;
    assign rv[g]  = bus.route_valid_dout;
    assign oh[g]  = bus.route_onehot_dout;
    assign err[g] = bus.route_err_dout;

    adaptive_route_unit #(
      .PORT_DIR(3'(P_PORT[g])), .X_LOCAL(P_X[g]), .Y_LOCAL(P_Y[g]), .X_WIDTH(P_XW[g]),
      .Y_WIDTH(P_YW[g]), .ADDR_W(4), .ALGO(P_ALGO[g]), .CREDIT_W(3)
    ) u_dut (
      .clk(clk), .reset(rst), .bus(bus)
    );
  end

  task automatic check(input string name, input int d, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %b expected %b at %0t", name, d, act, exp, $time);
    end
  endtask

  // Productive set straight from the routing rules, then dropped to port order.
  function automatic logic [3:0] exp_cand(input int d, input int x, input int y, input logic done);
    logic [4:0] want;
    logic [3:0] rel;
    int j;
    want = '0;
    rel  = '0;
    j    = 0;
    if (x < 1 || x > P_XW[d] || y < 1 || y > P_YW[d]) return 4'b0000;
    case (P_ALGO[d])
      0: if (x != P_X[d]) begin
           want[1] = x > P_X[d];
           want[3] = x < P_X[d];
         end else begin
           want[2] = y > P_Y[d];
           want[4] = y < P_Y[d];
         end
      1: if (x < P_X[d]) want[3] = 1'b1;
         else begin
           want[1] = x > P_X[d];
           want[2] = y > P_Y[d];
           want[4] = y < P_Y[d];
         end
      default: begin
        want[3] = x < P_X[d];
        want[4] = y < P_Y[d];
        if (want == 5'b0) begin
          want[1] = x > P_X[d];
          want[2] = y > P_Y[d];
        end
      end
    endcase
    if (x == P_X[d] && y == P_Y[d]) begin
      want[0] = !done;
      if (P_X[d] == 1)       want[3] = 1'b1;
      if (P_X[d] == P_XW[d]) want[1] = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      if (k != P_PORT[d]) begin
        rel[j[1:0]] = want[k[2:0]];
        j++;
      end
    end
    return rel;
  endfunction

  // Returns chosen channel index, or -1 when nothing may be issued yet.
  function automatic int choose(input logic [3:0] c, input logic [11:0] credits, input int rr);
    int best;
    best = 0;
`ifdef ROUTE_CREDIT_SEL_EN
    for (int i = 0; i < 4; i++)
      if (c[i] && int'(credits[i*3 +: 3]) > best) best = int'(credits[i*3 +: 3]);
    if (best == 0) return -1;
    for (int k = 0; k < 4; k++)
      if (c[(rr + k) % 4] && int'(credits[((rr + k) % 4)*3 +: 3]) == best) return (rr + k) % 4;
`else
    for (int i = 0; i < 4; i++)
      if (c[i]) return (credits[i*3 +: 3] != 3'd0) ? i : -1;
`endif
    return -1;
  endfunction

  int         m_phase [4];
  logic [3:0] m_x [4], m_y [4], m_route [4];
  logic       m_done [4], m_err [4];
  int         m_rr [4];

  always @(posedge clk) begin
    for (int d = 0; d < 4; d++) begin
      logic [3:0] c;
      int s;
      c = exp_cand(d, int'(m_x[d]), int'(m_y[d]), m_done[d]);
      s = choose(c, cr[d], m_rr[d]);
      if (rst) begin
        m_phase[d] <= PH_IDLE;
        m_err[d]   <= 1'b0;
        m_rr[d]    <= 0;
      end else if (m_phase[d] == PH_IDLE) begin
        if (hv[d]) begin
          m_x[d] <= xf[d];
          m_y[d] <= yf[d];
          m_done[d] <= dn[d];
          m_phase[d] <= PH_SEL;
        end
      end else if (m_phase[d] == PH_SEL) begin
        if (c == 4'b0000) begin
          m_err[d]   <= 1'b1;
          m_phase[d] <= PH_IDLE;
        end else if (s >= 0) begin
          m_route[d] <= 4'(1 << s);
          m_rr[d]    <= (s + 1) % 4;
          m_phase[d] <= PH_HOLD;
        end
      end else if (tl[d]) begin
        m_phase[d] <= PH_IDLE;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 4; d++) begin
        logic [3:0] c;
        c = (m_phase[d] == PH_IDLE) ? 4'b0000 : exp_cand(d, int'(m_x[d]), int'(m_y[d]), m_done[d]);
        check("model_ready", d, 4'(rdy[d]), 4'(m_phase[d] == PH_IDLE));
        check("model_route_valid", d, 4'(rv[d]), 4'(m_phase[d] == PH_HOLD));
        check("model_err", d, 4'(err[d]), 4'(m_err[d]));
        check("model_channels", d, vc[d], c);
        if (m_phase[d] == PH_HOLD) check("model_onehot", d, oh[d], m_route[d]);
      end
    end
  end

  task automatic present(input int d, input int x, input int y, input logic done, input logic [11:0] credits);
    xf[d] = 4'(x);
    yf[d] = 4'(y);
    dn[d] = done;
    cr[d] = credits;
    hv[d] = 1'b1;
    @(negedge clk);
    hv[d] = 1'b0;
  endtask

  task automatic finish_packet(input int d);
    tl[d] = 1'b1;
    @(negedge clk);
    tl[d] = 1'b0;
  endtask

  initial begin
    hv = '0; dn = '0; tl = '0; xf = '0; yf = '0; cr = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    started = 1'b1;
    check("rst_ready", 0, 4'(rdy[0]), 4'd1);
    check("rst_route_valid", 0, 4'(rv[0]), 4'd0);
    check("rst_onehot", 0, oh[0], 4'b0000);
    check("rst_channels", 0, vc[0], 4'b0000);
    check("rst_err", 0, 4'(err[0]), 4'd0);
    rst = 1'b0;
    @(negedge clk);

    // West-first at (2,2) from X_NEG, dest (4,3): X_POS and Y_POS, tied credits.
    present(0, 4, 3, 1'b1, {3'd0, 3'd3, 3'd3, 3'd0});
    check("t1_channels", 0, vc[0], 4'b0110);
    check("t1_not_yet", 0, 4'(rv[0]), 4'd0);
    @(negedge clk);
    check("t1_route_valid", 0, 4'(rv[0]), 4'd1);
    check("t1_onehot", 0, oh[0], 4'b0010);

    // Single-flit tail on first HOLD cycle with next head already waiting.
    tl[0] = 1'b1;
    hv[0] = 1'b1;
    @(negedge clk);
    tl[0] = 1'b0;
    check("t4_released", 0, 4'(rv[0]), 4'd0);
    check("t4_ready", 0, 4'(rdy[0]), 4'd1);
    @(negedge clk);
    hv[0] = 1'b0;
    check("t4_accepted", 0, 4'(rdy[0]), 4'd0);
    @(negedge clk);
`ifdef ROUTE_CREDIT_SEL_EN
    check("t4_rr_onehot", 0, oh[0], 4'b0100);
`else
    check("t4_rr_onehot", 0, oh[0], 4'b0010);
`endif
    finish_packet(0);

    // X_POS credit 1, Y_POS credit 7.
    present(0, 4, 3, 1'b1, {3'd0, 3'd7, 3'd1, 3'd0});
    @(negedge clk);
`ifdef ROUTE_CREDIT_SEL_EN
    check("t6_onehot", 0, oh[0], 4'b0100);
`else
    check("t6_onehot", 0, oh[0], 4'b0010);
`endif
    finish_packet(0);

    // Arrived at (2,2), not yet processed: eject to PE.
    present(0, 2, 2, 1'b0, {3'd0, 3'd0, 3'd0, 3'd1});
    check("pe_channels", 0, vc[0], 4'b0001);
    @(negedge clk);
    check("pe_onehot", 0, oh[0], 4'b0001);
    finish_packet(0);

    // Dest (1,2): only X_NEG productive, which is the input port itself.
    present(0, 1, 2, 1'b1, {3'd3, 3'd3, 3'd3, 3'd3});
    check("t2_channels", 0, vc[0], 4'b0000);
    check("t2_busy", 0, 4'(rdy[0]), 4'd0);
    @(negedge clk);
    check("t2_err", 0, 4'(err[0]), 4'd1);
    check("t2_ready", 0, 4'(rdy[0]), 4'd1);

    // Terminal column X_LOCAL=1, dest==local from PE: X_NEG only, waits for credit.
    present(1, 1, 2, 1'b0, 12'd0);
    check("t3_channels", 1, vc[1], 4'b0100);
    repeat (3) begin
      @(negedge clk);
      check("t3_waiting", 1, 4'(rv[1]), 4'd0);
    end
    cr[1] = {3'd0, 3'd1, 3'd0, 3'd0};
    @(negedge clk);
    check("t3_route_valid", 1, 4'(rv[1]), 4'd1);
    check("t3_onehot", 1, oh[1], 4'b0100);

    // Negative-first at (2,2) from PE: (1,3) -> X_NEG, (3,3) -> X_POS/Y_POS.
    present(2, 1, 3, 1'b0, {3'd0, 3'd2, 3'd0, 3'd0});
    check("nf_neg_channels", 2, vc[2], 4'b0100);
    @(negedge clk);
    finish_packet(2);
    present(2, 3, 3, 1'b0, {3'd0, 3'd0, 3'd6, 3'd4});
    check("nf_pos_channels", 2, vc[2], 4'b0011);
    @(negedge clk);
`ifdef ROUTE_CREDIT_SEL_EN
    check("nf_onehot", 2, oh[2], 4'b0010);
`else
    check("nf_onehot", 2, oh[2], 4'b0001);
`endif
    finish_packet(2);

    // XY at (2,2) from PE: (3,3) goes X first, (2,1) goes Y_NEG.
    present(3, 3, 3, 1'b0, {3'd0, 3'd0, 3'd0, 3'd2});
    check("xy_x_channels", 3, vc[3], 4'b0001);
    @(negedge clk);
    finish_packet(3);
    present(3, 2, 1, 1'b0, {3'd1, 3'd0, 3'd0, 3'd0});
    check("xy_y_channels", 3, vc[3], 4'b1000);
    @(negedge clk);
    check("xy_onehot", 3, oh[3], 4'b1000);
    finish_packet(3);

    // Reset while dut0 holds a route and carries a sticky error.
    present(0, 4, 3, 1'b1, {3'd0, 3'd3, 3'd3, 3'd0});
    @(negedge clk);
    check("t5_holding", 0, 4'(rv[0]), 4'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_ready", 0, 4'(rdy[0]), 4'd1);
    check("t5_route_valid", 0, 4'(rv[0]), 4'd0);
    check("t5_onehot", 0, oh[0], 4'b0000);
    check("t5_channels", 0, vc[0], 4'b0000);
    check("t5_err", 0, 4'(err[0]), 4'd0);
    check("t5_hold1", 1, 4'(rv[1]), 4'd0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
